// File: rtl/axi4_rd_burst_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : axi4_rd_burst_master
//  Purpose  : AXI4 read-only burst master for cache line refill. It accepts
//             one line request, issues a single AR burst and streams the
//             returned beats back with a beat index. It can abandon a request,
//             in which case the burst is drained and no beats are forwarded.
//             Only one burst is outstanding at a time.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    ACLK, ARESETn            clock, asynchronous active-low reset
//    rd_req/rd_addr/rd_rdy    line request handshake (accepted on req & rdy)
//    cancel                   abandon the current request
//    ret_valid/data/idx/last/err  returned beat, one-cycle pulse per beat
//    AR* / R*                 AXI4 read address and read data channels
//  Configuration macro
//    AXI_RD_WRAP_EN           WRAP bursts, critical word first; the default
//                             build issues line-aligned INCR bursts
// ============================================================================
module axi4_rd_burst_master #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  int BEATS  = 4,
    parameter  int ID_W   = 4,
    parameter  int ID_VAL = 0,
    localparam int IDX_W  = $clog2(BEATS) + 1
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    // cache side
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_rdy,
    input  logic              cancel,
    output logic              ret_valid,
    output logic [DATA_W-1:0] ret_data,
    output logic [IDX_W-1:0]  ret_idx,
    output logic              ret_last,
    output logic              ret_err,
    // AXI read address channel
    output logic [ID_W-1:0]   ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    output logic              ARLOCK,
    output logic [3:0]        ARCACHE,
    output logic [2:0]        ARPROT,
    output logic [3:0]        ARQOS,
    output logic [3:0]        ARREGION,
    // AXI read data channel
    input  logic [ID_W-1:0]   RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY
);

    localparam int c_BYTES      = DATA_W / 8;
    localparam int c_SIZE       = $clog2(c_BYTES);
    localparam int c_LINE_BYTES = BEATS * c_BYTES;

    localparam logic [ADDR_W-1:0] c_LINE_MASK = ~(ADDR_W'(c_LINE_BYTES - 1));
    localparam logic [ADDR_W-1:0] c_BEAT_MASK = ~(ADDR_W'(c_BYTES - 1));
    localparam logic [ADDR_W-1:0] c_OFF_MASK  = ADDR_W'(BEATS - 1);
    localparam logic [IDX_W-1:0]  c_LAST_CNT  = IDX_W'(BEATS - 1);
    localparam logic [IDX_W-1:0]  c_IDX_MASK  = IDX_W'(BEATS - 1);

`ifdef AXI_RD_WRAP_EN
    // A single-beat WRAP burst is illegal in AXI, so BEATS=1 stays INCR.
    localparam bit c_WRAP = (BEATS > 1);
`else
    localparam bit c_WRAP = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_DATA  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_araddr;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_rd_rdy;
    logic                r_cancel_pend;
    logic [IDX_W-1:0]    r_beat_cnt;
    logic [IDX_W-1:0]    r_start;
    logic                r_overrun;
    logic                r_ret_valid;
    logic [DATA_W-1:0]   r_ret_data;
    logic [IDX_W-1:0]    r_ret_idx;
    logic                r_ret_last;
    logic                r_ret_err;

    logic                w_beat;
    logic                w_exp_last;
    logic                w_beat_err;
    logic [IDX_W-1:0]    w_idx;
    logic [IDX_W-1:0]    w_req_off;
    logic [ADDR_W-1:0]   w_req_araddr;

    // Word offset of the requested address within its line.
    assign w_req_off    = IDX_W'((rd_addr >> c_SIZE) & c_OFF_MASK);
    assign w_req_araddr = c_WRAP ? (rd_addr & c_BEAT_MASK) : (rd_addr & c_LINE_MASK);

    assign w_beat     = RVALID & r_rready;
    assign w_exp_last = (r_beat_cnt == c_LAST_CNT);
    // Once the beat count has saturated without RLAST every further beat is
    // an overrun, so the flag keeps flagging until RLAST finally arrives.
    assign w_beat_err = (RRESP != 2'b00) | (RID != ID_W'(ID_VAL)) |
                        (RLAST != w_exp_last) | r_overrun;
    assign w_idx      = (r_start + r_beat_cnt) & c_IDX_MASK;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state       <= S_IDLE;
            r_araddr      <= '0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rd_rdy      <= 1'b1;
            r_cancel_pend <= 1'b0;
            r_beat_cnt    <= '0;
            r_start       <= '0;
            r_overrun     <= 1'b0;
            r_ret_valid   <= 1'b0;
            r_ret_data    <= '0;
            r_ret_idx     <= '0;
            r_ret_last    <= 1'b0;
            r_ret_err     <= 1'b0;
        end else begin
            r_ret_valid <= 1'b0;
            r_ret_last  <= 1'b0;
            r_ret_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // cancel is deliberately ignored here, even alongside rd_req
                    if (rd_req) begin
                        r_araddr      <= w_req_araddr;
                        r_start       <= c_WRAP ? w_req_off : '0;
                        r_beat_cnt    <= '0;
                        r_overrun     <= 1'b0;
                        r_cancel_pend <= 1'b0;
                        r_arvalid     <= 1'b1;
                        r_rd_rdy      <= 1'b0;
                        r_state       <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    // The address handshake must still complete after cancel.
                    if (cancel)
                        r_cancel_pend <= 1'b1;
                    if (ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= (r_cancel_pend | cancel) ? S_DRAIN : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        if (!cancel) begin
                            r_ret_valid <= 1'b1;
                            r_ret_data  <= RDATA;
                            r_ret_idx   <= w_idx;
                            r_ret_last  <= RLAST;
                            r_ret_err   <= w_beat_err;
                            if (r_beat_cnt != c_LAST_CNT)
                                r_beat_cnt <= r_beat_cnt + 1'b1;
                            else if (!RLAST)
                                r_overrun <= 1'b1;
                        end
                        if (RLAST) begin
                            r_rready      <= 1'b0;
                            r_rd_rdy      <= 1'b1;
                            r_cancel_pend <= 1'b0;
                            r_state       <= S_IDLE;
                        end else if (cancel) begin
                            r_state <= S_DRAIN;
                        end
                    end else if (cancel) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_beat && RLAST) begin
                        r_rready      <= 1'b0;
                        r_rd_rdy      <= 1'b1;
                        r_cancel_pend <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_rdy    = r_rd_rdy;
    assign ret_valid = r_ret_valid;
    assign ret_data  = r_ret_data;
    assign ret_idx   = r_ret_idx;
    assign ret_last  = r_ret_last;
    assign ret_err   = r_ret_err;

    assign ARID     = ID_W'(ID_VAL);
    assign ARADDR   = r_araddr;
    assign ARLEN    = 8'(BEATS - 1);
    assign ARSIZE   = 3'(c_SIZE);
    assign ARBURST  = c_WRAP ? 2'b10 : 2'b01;
    assign ARVALID  = r_arvalid;
    assign ARLOCK   = 1'b0;
    assign ARCACHE  = 4'd0;
    assign ARPROT   = 3'd0;
    assign ARQOS    = 4'd0;
    assign ARREGION = 4'd0;
    assign RREADY   = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi4_rd_burst_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_axi4_rd_burst_master
//  Purpose  : Scoreboard bench for axi4_rd_burst_master (BEATS=4, 32-bit).
//             Stimulus pushes expected AR requests and returned beats into
//             queues; a monitor pops and compares whenever the DUT presents
//             an AR handshake or a ret_valid pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi4_rd_burst_master;

    localparam int IDX_W = 3;

`ifdef AXI_RD_WRAP_EN
    localparam logic [1:0]  C_BURST  = 2'b10;
    localparam logic [31:0] T1_ADDR  = 32'h1000_0018;
    localparam logic [31:0] T1_AR    = 32'h1000_0018;
    localparam int          T1_START = 2;
`else
    localparam logic [1:0]  C_BURST  = 2'b01;
    localparam logic [31:0] T1_ADDR  = 32'h1000_0014;
    localparam logic [31:0] T1_AR    = 32'h1000_0010;
    localparam int          T1_START = 0;
`endif

    logic              ACLK = 1'b0;
    logic              ARESETn;
    logic              rd_req, rd_rdy, cancel;
    logic [31:0]       rd_addr;
    logic              ret_valid, ret_last, ret_err;
    logic [31:0]       ret_data;
    logic [IDX_W-1:0]  ret_idx;
    logic [3:0]        ARID, ARCACHE, ARQOS, ARREGION;
    logic [31:0]       ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE, ARPROT;
    logic [1:0]        ARBURST;
    logic              ARVALID, ARREADY, ARLOCK;
    logic [3:0]        RID;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RLAST, RVALID, RREADY;

    axi4_rd_burst_master #(
        .ADDR_W(32), .DATA_W(32), .BEATS(4), .ID_W(4), .ID_VAL(0)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy), .cancel(cancel),
        .ret_valid(ret_valid), .ret_data(ret_data), .ret_idx(ret_idx),
        .ret_last(ret_last), .ret_err(ret_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARQOS(ARQOS),
        .ARREGION(ARREGION),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0]      data;
        logic [IDX_W-1:0] idx;
        logic             last;
        logic             err;
    } beat_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  burst;
    } ar_t;

    beat_t exp_q[$];
    ar_t   ar_q[$];
    beat_t mb;
    ar_t   ma;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues.
    always @(negedge ACLK) begin
        if (ARESETn === 1'b1 && ret_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ret_valid", ret_valid, 0);
            end else begin
                mb = exp_q.pop_front();
                check("ret_data", ret_data, mb.data);
                check("ret_idx",  ret_idx,  mb.idx);
                check("ret_last", ret_last, mb.last);
                check("ret_err",  ret_err,  mb.err);
            end
        end
        if (ARESETn === 1'b1 && ARVALID === 1'b1 && ARREADY === 1'b1) begin
            if (ar_q.size() == 0) begin
                check("unexpected_ar", ARVALID, 0);
            end else begin
                ma = ar_q.pop_front();
                check("araddr",  ARADDR,  ma.addr);
                check("arburst", ARBURST, ma.burst);
                check("arlen",   ARLEN,   8'd3);
                check("arsize",  ARSIZE,  3'd2);
                check("arid",    ARID,    4'd0);
            end
        end
    end

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input int idx, input bit last, input bit err);
        exp_q.push_back('{d, IDX_W'(idx), last, err});
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] exp_ar);
        int guard;
        guard = 0;
        while (rd_rdy !== 1'b1 && guard < 50) begin
            tick;
            guard++;
        end
        check("rd_rdy_idle", rd_rdy, 1);
        ar_q.push_back('{exp_ar, C_BURST});
        rd_req  = 1'b1;
        rd_addr = addr;
        tick;
        rd_req  = 1'b0;
        check("rd_rdy_accepted", rd_rdy, 0);
        check("arvalid_up", ARVALID, 1);
    endtask

    task automatic ar_accept(input int delay);
        for (int i = 0; i < delay; i++) begin
            tick;
            check("arvalid_hold", ARVALID, 1);
        end
        ARREADY = 1'b1;
        tick;
        ARREADY = 1'b0;
        check("arvalid_drop", ARVALID, 0);
        check("rready_up", RREADY, 1);
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] resp, input bit last,
                        input logic [3:0] id, input bit cxl);
        int guard;
        guard = 0;
        while (RREADY !== 1'b1 && guard < 50) begin
            tick;
            guard++;
        end
        check("rready_beat", RREADY, 1);
        check("rd_rdy_busy", rd_rdy, 0);
        RVALID = 1'b1;
        RDATA  = d;
        RRESP  = resp;
        RLAST  = last;
        RID    = id;
        cancel = cxl;
        tick;
        RVALID = 1'b0;
        RLAST  = 1'b0;
        RRESP  = 2'b00;
        RID    = 4'd0;
        cancel = 1'b0;
    endtask

    task automatic normal_line(input logic [31:0] addr, input logic [31:0] base_d);
        issue(addr, addr);
        ar_accept(0);
        for (int k = 0; k < 4; k++) begin
            push(base_d + 32'(k), k, k == 3, 1'b0);
            beat(base_d + 32'(k), 2'b00, k == 3, 4'd0, 1'b0);
        end
        tick;
        check("rd_rdy_after_line", rd_rdy, 1);
    endtask

    initial begin
        int guard;
        ARESETn = 1'b0;
        rd_req = 1'b0; rd_addr = '0; cancel = 1'b0; ARREADY = 1'b0;
        RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;
        tick; tick; tick;
        ARESETn = 1'b1;
        tick;
        check("rst_rd_rdy",    rd_rdy,    1);
        check("rst_arvalid",   ARVALID,   0);
        check("rst_rready",    RREADY,    0);
        check("rst_ret_valid", ret_valid, 0);
        check("rst_araddr",    ARADDR,    0);
        check("rst_ret_data",  ret_data,  0);

        // T1 / T2: basic line fill, ARREADY after 2 cycles
        issue(T1_ADDR, T1_AR);
        ar_accept(2);
        for (int k = 0; k < 4; k++) begin
            push(32'hA0 + 32'(k), (T1_START + k) % 4, k == 3, 1'b0);
            beat(32'hA0 + 32'(k), 2'b00, k == 3, 4'd0, 1'b0);
        end
        tick;
        check("t1_rd_rdy_after", rd_rdy, 1);

        // T3: cancel during ADDR, ARREADY low 5 cycles, all beats drained
        issue(32'h2000_0000, 32'h2000_0000);
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        check("t3_arvalid_after_cancel", ARVALID, 1);
        ar_accept(4);
        for (int k = 0; k < 4; k++)
            beat(32'hB0 + 32'(k), 2'b00, k == 3, 4'd0, 1'b0);
        tick;
        check("t3_rd_rdy_after", rd_rdy, 1);
        check("t3_rready_low", RREADY, 0);

        // T4: cancel coincident with beat 1, then a normal request
        issue(32'h3000_0040, 32'h3000_0040);
        ar_accept(0);
        push(32'hC0, 0, 1'b0, 1'b0);
        beat(32'hC0, 2'b00, 1'b0, 4'd0, 1'b0);
        beat(32'hC1, 2'b00, 1'b0, 4'd0, 1'b1);
        beat(32'hC2, 2'b00, 1'b0, 4'd0, 1'b0);
        beat(32'hC3, 2'b00, 1'b1, 4'd0, 1'b0);
        tick;
        check("t4_rd_rdy_after", rd_rdy, 1);
        normal_line(32'h3000_0080, 32'hD0);

        // T5: SLVERR on beat 2 only
        issue(32'h4000_0000, 32'h4000_0000);
        ar_accept(1);
        for (int k = 0; k < 4; k++) begin
            push(32'hE0 + 32'(k), k, k == 3, k == 2);
            beat(32'hE0 + 32'(k), (k == 2) ? 2'b10 : 2'b00, k == 3, 4'd0, 1'b0);
        end

        // RID mismatch on beat 0
        issue(32'h4000_0100, 32'h4000_0100);
        ar_accept(0);
        for (int k = 0; k < 4; k++) begin
            push(32'hF0 + 32'(k), k, k == 3, k == 0);
            beat(32'hF0 + 32'(k), 2'b00, k == 3, (k == 0) ? 4'd5 : 4'd0, 1'b0);
        end

        // Early RLAST on beat 1
        issue(32'h4000_0200, 32'h4000_0200);
        ar_accept(0);
        push(32'h70, 0, 1'b0, 1'b0);
        beat(32'h70, 2'b00, 1'b0, 4'd0, 1'b0);
        push(32'h71, 1, 1'b1, 1'b1);
        beat(32'h71, 2'b00, 1'b1, 4'd0, 1'b0);
        tick;
        check("early_last_rd_rdy", rd_rdy, 1);

        // Missing RLAST: five beats, index saturates at 3
        issue(32'h4000_0300, 32'h4000_0300);
        ar_accept(0);
        push(32'h80, 0, 1'b0, 1'b0);
        push(32'h81, 1, 1'b0, 1'b0);
        push(32'h82, 2, 1'b0, 1'b0);
        push(32'h83, 3, 1'b0, 1'b1);
        push(32'h84, 3, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++)
            beat(32'h80 + 32'(k), 2'b00, k == 4, 4'd0, 1'b0);
        tick;
        check("overrun_rd_rdy", rd_rdy, 1);

        // T6: reset asserted during beat 1 of a burst
        issue(32'h5000_0000, 32'h5000_0000);
        ar_accept(1);
        push(32'h90, 0, 1'b0, 1'b0);
        beat(32'h90, 2'b00, 1'b0, 4'd0, 1'b0);
        tick;
        RVALID = 1'b1; RDATA = 32'h91; RLAST = 1'b0;
        #2;
        ARESETn = 1'b0;
        #1;
        check("t6_ret_valid", ret_valid, 0);
        check("t6_arvalid",   ARVALID,   0);
        check("t6_rready",    RREADY,    0);
        check("t6_ret_data",  ret_data,  0);
        check("t6_ret_idx",   ret_idx,   0);
        check("t6_ret_last",  ret_last,  0);
        check("t6_araddr",    ARADDR,    0);
        RVALID = 1'b0;
        tick; tick;
        ARESETn = 1'b1;
        tick;
        check("t6_rd_rdy_release", rd_rdy, 1);
        check("t6_rready_release", RREADY, 0);
        normal_line(32'h6000_0010, 32'h60);

        guard = 0;
        while ((exp_q.size() != 0 || ar_q.size() != 0) && guard < 20) begin
            tick;
            guard++;
        end
        check("scoreboard_drained", exp_q.size() + ar_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
